// File: rtl/pcm_i2s_tx.sv
// Stereo PCM pair assembler, frame FIFO and I2S serializer with bit/word clocks.
// Define PCM_I2S_TX_LEFT_JUSTIFIED_EN for left-justified word-select timing.
module pcm_i2s_tx #(
  parameter int DEPTH_LOG2 = 3,
  parameter int BCLK_DIV   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb_sample,
  input  logic                  chan,
  input  logic [15:0]           din,
  input  logic                  clr_flags,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  streaming,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = (BCLK_DIV > 1) ? $clog2(2 * BCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HI = CW'(BCLK_DIV);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);

  typedef enum logic {
    PRIME,
    STREAM
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]         cnt;
  logic [4:0]            slot;
  logic [4:0]            nslot;
  logic                  wrap;
  logic                  frame_edge;
  logic                  lr_next;
  logic [31:0]           shreg;
  logic                  left_valid;
  logic [15:0]           left_hold;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  pair_err;
  logic                  ovf_set;
  logic                  uf_set;

  // Slot-start work is committed on the edge that wraps the divider,
  // so the new slot's outputs are valid from divider count 0.
  assign wrap       = (cnt == CNT_LAST);
  assign nslot      = slot + 5'd1;
  assign frame_edge = wrap && (slot == 5'd31);

`ifdef PCM_I2S_TX_LEFT_JUSTIFIED_EN
  assign lr_next = nslot[4];
`else
  assign lr_next = (nslot >= 5'd15) && (nslot <= 5'd30);
`endif

  assign full     = (fifo_level == LVL_FULL);
  assign empty    = (fifo_level == '0);
  assign push_req = stb_sample && chan && left_valid;
  assign push     = push_req && (!full || pop);
  assign pair_err = stb_sample && (chan ? !left_valid : left_valid);
  assign ovf_set  = pair_err || (push_req && !push);

  assign i2s_bclk  = (cnt >= CNT_HI);
  assign i2s_sdata = shreg[31];
  assign streaming = (state == STREAM);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    uf_set  = 1'b0;
    if (frame_edge) begin
      unique case (state)
        PRIME: begin
          if (fifo_level >= LVL_HALF) begin
            pop     = 1'b1;
            state_n = STREAM;
          end
        end
        STREAM: begin
          if (empty) begin
            uf_set  = 1'b1;
            state_n = PRIME;
          end else begin
            pop = 1'b1;
          end
        end
        default: state_n = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      slot      <= '0;
      i2s_lrclk <= 1'b0;
      shreg     <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) begin
        slot      <= nslot;
        i2s_lrclk <= lr_next;
        if (frame_edge) begin
          shreg <= pop ? mem[rd_ptr] : '0;
        end else begin
          shreg <= {shreg[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_valid <= 1'b0;
      left_hold  <= '0;
    end else if (stb_sample) begin
      if (!chan) begin
        left_valid <= 1'b1;
        left_hold  <= din;
      end else begin
        left_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {left_hold, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A flag-setting event in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (uf_set) underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Scoreboard bench for pcm_i2s_tx: frame-level queue model, randomized pairs.
// Checks serial frames, clocks, level and sticky flags every cycle.
module tb_pcm_i2s_tx;

  localparam int DL = 3;
  localparam int B = 2;
  localparam int DEPTH = 1 << DL;
  localparam int FR = 64 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb_sample = 1'b0;
  logic        chan = 1'b0;
  logic [15:0] din = '0;
  logic        clr_flags = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [DL:0] fifo_level;
  logic        streaming;
  logic        overflow;
  logic        underflow;

  pcm_i2s_tx #(.DEPTH_LOG2(DL), .BCLK_DIV(B)) dut (
    .clk(clk), .rst(rst), .stb_sample(stb_sample), .chan(chan),
    .din(din), .clr_flags(clr_flags), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .streaming(streaming),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: cycles since reset, frame queue, pairing and flags.
  int          k = 0;
  bit          rs_q = 1'b1;
  logic [31:0] q[$];
  logic [31:0] expq[$];
  bit          lv = 0;
  logic [15:0] lh = '0;
  bit          m_ovf = 0;
  bit          m_uf = 0;
  bit          m_strm = 0;

  always @(posedge clk) begin
    bit popm, ovs, ufs;
    int lvl;
    logic [31:0] frm;
    if (rst) begin
      k = 0;
      rs_q = 1;
      q.delete();
      expq.delete();
      expq.push_back(32'h0);
      lv = 0;
      m_ovf = 0;
      m_uf = 0;
      m_strm = 0;
    end else begin
      rs_q = 0;
      lvl = q.size();
      popm = 0;
      ufs = 0;
      ovs = 0;
      frm = 32'h0;
      if ((k % FR) == FR - 1) begin
        if (m_strm) begin
          if (lvl > 0) popm = 1;
          else begin
            ufs = 1;
            m_strm = 0;
          end
        end else if (lvl >= DEPTH / 2) begin
          popm = 1;
          m_strm = 1;
        end
        if (popm) frm = q.pop_front();
        expq.push_back(frm);
      end
      if (stb_sample) begin
        if (!chan) begin
          if (lv) ovs = 1;
          lv = 1;
          lh = din;
        end else if (lv) begin
          if (lvl < DEPTH || popm) q.push_back({lh, din});
          else ovs = 1;
          lv = 0;
        end else begin
          ovs = 1;
        end
      end
      if (ovs) m_ovf = 1;
      else if (clr_flags) m_ovf = 0;
      if (ufs) m_uf = 1;
      else if (clr_flags) m_uf = 0;
      k++;
    end
  end

  // Monitor: samples sdata mid-slot, compares whole frames against the queue.
  logic [31:0] fr = '0;
  int          nb = 0;

  always @(negedge clk) begin
    int slot, ph;
    bit lr_exp;
    if (rs_q) begin
      nb = 0;
    end else begin
      ph = k % (2 * B);
      slot = (k / (2 * B)) % 32;
`ifdef PCM_I2S_TX_LEFT_JUSTIFIED_EN
      lr_exp = (slot >= 16);
`else
      lr_exp = (slot >= 15) && (slot <= 30);
`endif
      chk("bclk", 32'(i2s_bclk), 32'(ph >= B));
      chk("lrclk", 32'(i2s_lrclk), 32'(lr_exp));
      chk("streaming", 32'(streaming), 32'(m_strm));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_uf));
      if (ph == B) begin
        fr[31-slot] = i2s_sdata;
        nb++;
        if (slot == 31) begin
          if (nb == 32) begin
            if (expq.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL frame: got %h expected none queued", fr);
            end else begin
              chk("frame", fr, expq.pop_front());
            end
          end
          nb = 0;
        end
      end
    end
  end

  task automatic wait_ph(input int ph);
    do @(negedge clk); while ((k % FR) != ph);
  endtask

  task automatic smp(input bit c, input logic [15:0] d);
    stb_sample = 1'b1;
    chan = c;
    din = d;
    @(negedge clk);
    stb_sample = 1'b0;
  endtask

  task automatic pair(input logic [15:0] l, input logic [15:0] r);
    smp(1'b0, l);
    smp(1'b1, r);
  endtask

  task automatic clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic rand_phase(input int cycles);
    bit c;
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 15) == 0) c = 1'($urandom);
        stb_sample = 1'b1;
        chan = c;
        din = 16'($urandom);
        c = ~c;
      end
      clr_flags = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      stb_sample = 1'b0;
      clr_flags = 1'b0;
    end
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bclk", 32'(i2s_bclk), 32'h0);
    chk("rst_lrclk", 32'(i2s_lrclk), 32'h0);
    chk("rst_sdata", 32'(i2s_sdata), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_streaming", 32'(streaming), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_uf", 32'(underflow), 32'h0);
    rst = 1'b0;
    repeat (2 * FR) @(negedge clk);

    wait_ph(2);
    pair(16'h8001, 16'h7FFE);
    for (int i = 0; i < 3; i++) pair(16'($urandom), 16'($urandom));
    wait_ph(1);
    chk("basic_streaming", 32'(streaming), 32'h1);
    repeat (4 * FR) @(negedge clk);
    chk("uf_set", 32'(underflow), 32'h1);
    chk("uf_streaming", 32'(streaming), 32'h0);
    clr();
    chk("uf_clr", 32'(underflow), 32'h0);

    wait_ph(2);
    for (int i = 0; i < 9; i++) pair(16'($urandom), 16'($urandom));
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'h1);
    repeat (10 * FR) @(negedge clk);
    clr();

    wait_ph(2);
    smp(1'b1, 16'h1111);
    smp(1'b0, 16'h2222);
    smp(1'b0, 16'h3333);
    smp(1'b1, 16'h4444);
    chk("pair_ovf", 32'(overflow), 32'h1);
    chk("pair_level", 32'(fifo_level), 32'd1);
    for (int i = 0; i < 3; i++) pair(16'($urandom), 16'($urandom));
    repeat (6 * FR) @(negedge clk);
    clr();

    wait_ph(2);
    for (int i = 0; i < 8; i++) pair(16'($urandom), 16'($urandom));
    smp(1'b0, 16'($urandom));
    chk("full_level", 32'(fifo_level), 32'd8);
    wait_ph(FR - 1);
    smp(1'b1, 16'($urandom));
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    repeat (10 * FR) @(negedge clk);
    clr();

    rand_phase(6 * FR);
    wait_ph($urandom_range(40, 100));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rand_phase(5 * FR);
    repeat (3 * FR) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_i2s_tx.md
# pcm_i2s_tx

Stereo PCM-to-I2S serializer downstream of the audio decimation filter. It takes the signed 16-bit samples the filter emits once per channel per PCM period and pairs them into left/right frames. Frames are buffered in a small FIFO and shifted out as a continuous I2S (or left-justified) bitstream with generated bit and word clocks. It absorbs the jitter between filter completion and the fixed-rate serial frame and flags overrun/underrun.

## Interface
- `DEPTH_LOG2`, 3, log2 of FIFO depth in stereo frames (depth 8).
- `BCLK_DIV`, 8, clk cycles per bclk half-period; must be ≥1.
- `clk`  in  1  system clock; everything is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stb_sample`  in  1  one-cycle pulse: `din`/`chan` valid.
- `chan`  in  1  0 = left sample, 1 = right sample.
- `din`  in  16  signed PCM sample.
- `clr_flags`  in  1  one-cycle pulse that clears `overflow` and `underflow`.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select; 0 = left.
- `i2s_sdata`  out  1  serial data, MSB first.
- `fifo_level`  out  DEPTH_LOG2+1  frames currently buffered.
- `streaming`  out  1  1 while in the STREAM state.
- `overflow`  out  1  sticky: a frame or sample was dropped.
- `underflow`  out  1  sticky: FIFO was empty at a frame start while streaming.

## Operation
- Pair assembly:
  - `stb_sample` with `chan`=0 loads a left holding register and sets `left_valid`. A second left sample overwrites it and sets `overflow`.
  - `stb_sample` with `chan`=1 and `left_valid`=1 pushes {left, din} and clears `left_valid`.
  - `chan`=1 with `left_valid`=0 is dropped and sets `overflow`.
- FIFO:
  - DEPTH = 2^DEPTH_LOG2 entries, each 32 bits.
  - A push when full is dropped and sets `overflow`, unless a pop occurs in the same cycle. In that case the push is accepted and the level is unchanged.
  - Read/write pointers wrap modulo DEPTH; `fifo_level` uses a separate counter.
- Clock generation:
  - A divider counter counts 0..2·BCLK_DIV−1 and runs continuously from reset.
  - `i2s_bclk` = 0 for counts 0..BCLK_DIV−1, then 1.
  - Slot counter 0..31 advances when the divider wraps.
  - A "slot start" is divider count 0, i.e. the bclk falling edge.
- State machine:
  - PRIME: outputs zero frames. At a slot-0 start with `fifo_level` ≥ DEPTH/2, pop one frame and go to STREAM.
  - STREAM: at every slot-0 start, pop a frame if the FIFO is non-empty. If it is empty, set `underflow`, send a zero frame, and return to PRIME.
- Serializer:
  - The popped frame loads the 32-bit shift register at slot 0.
  - The register shifts one bit per slot start.
  - `i2s_sdata` in slot n is left[15−n] for n=0..15 and right[31−n] for n=16..31.
- `clr_flags` and a simultaneous flag-setting event: the set wins.

## Timing
- Reset values:
  - Outputs: `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0, `fifo_level`=0, `streaming`=0, `overflow`=0, `underflow`=0.
  - Internal: divider=0, slot=0, state PRIME, `left_valid`=0, FIFO emptied.
- A reset mid-frame abandons the frame immediately; the next cycle behaves as the first cycle after reset.
- Output registers are updated in the same cycle as the slot start.
- Push to `fifo_level` increment: 1 cycle.
- Frame period: 64·BCLK_DIV clk cycles.
- Word clock (I2S mode): `i2s_lrclk` = 1 in slots 15..30 and 0 in slots 31 and 0..14. This gives the one-bit delay before each MSB.
- `streaming` rises in the cycle after the slot-0 pop that leaves PRIME.

## Configuration
- `PCM_I2S_TX_LEFT_JUSTIFIED_EN`:
  - Defined: left-justified format. `i2s_lrclk` = 1 exactly in slots 16..31, so the MSB coincides with the lrclk edge. Data mapping is unchanged.
  - Undefined: standard I2S timing as specified above.

## Test plan
- **Reset/idle:** hold `rst` for 3 cycles, release, run 2 frames with no input. Required: `i2s_sdata`=0 throughout; `i2s_bclk` toggles every BCLK_DIV cycles; `streaming`=0.
- **Basic stream (BCLK_DIV=2, DEPTH_LOG2=3):** push 4 pairs, the first being L=16'h8001, R=16'h7FFE. Required: `streaming` rises after the next slot-0 start. In the first frame, sdata slots 0..15 = 1000_0000_0000_0001 and slots 16..31 = 0111_1111_1111_1110. Checked against lrclk per mode.
- **Underflow:** prime 4 frames, then stop input. Required: 4 frames are sent, then a zero frame; `underflow`=1; `streaming`=0. `clr_flags` then clears `underflow`.
- **Overflow:** push 9 pairs back-to-back before any pop. Required: `fifo_level`=8, `overflow`=1, and the 9th pair never appears on sdata.
- **Pairing errors:** send R without a preceding L, then L, L, R. Required: `overflow`=1; only one frame is pushed, containing the second L.
- **Full with simultaneous pop:** fill to 8 and time a push to coincide with a slot-0 pop. Required: `fifo_level` stays 8 and `overflow` stays 0.
